// File: rtl/stack_unit_if.sv
// Request/response bundle between the EX-stage stack requester and the stack unit.
interface stack_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 8
);
    logic             push;
    logic             pop;
    logic             err_clr;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] pop_data;
    logic [AW:0]      sp;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    // Requester side: issues push/pop/err_clr and observes results and status.
    modport master (
        output push, pop, err_clr, push_data,
        input  pop_data, sp, empty, full, ovf, unf
    );

    // Stack side: consumes requests and reports results and status.
    modport slave (
        input  push, pop, err_clr, push_data,
        output pop_data, sp, empty, full, ovf, unf
    );
endinterface

// File: rtl/stack_unit.sv
// Hardware LIFO stack: one-write/one-sync-read RAM, occupancy pointer,
// status flags and sticky overflow/underflow error flags.
module stack_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    stack_unit_if.slave bus
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW:0]      sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             pop_zero_q, pop_zero_d;
    logic [WIDTH-1:0] rd_data_q;

    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             ovf_set;
    logic             unf_set;
    logic [AW-1:0]    top_addr;
    logic [AW-1:0]    wr_addr;

    // Request qualification, addressing and next-state computation.
    always_comb begin
        empty    = (sp_q == '0);
        full     = (sp_q == (AW+1)'(DEPTH));
        // Low AW bits of sp minus one is the top slot, including sp==DEPTH.
        top_addr = sp_q[AW-1:0] - AW'(1);

        do_pop   = bus.pop && !empty;
        // A pop frees the top slot, so push+pop on a full stack still writes.
        do_push  = bus.push && (!full || do_pop);
        wr_addr  = do_pop ? top_addr : sp_q[AW-1:0];

        ovf_set  = bus.push && !bus.pop && full;
        unf_set  = bus.pop && empty;

        sp_d = sp_q;
        if (do_push && !do_pop) begin
            sp_d = sp_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            sp_d = sp_q - (AW+1)'(1);
        end

        pop_zero_d = pop_zero_q;
        if (bus.pop) begin
            pop_zero_d = !do_pop;
        end

        ovf_d = ovf_set || (ovf_q && !bus.err_clr);
        unf_d = unf_set || (unf_q && !bus.err_clr);
    end

    // Pointer, flag and pop-result-select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q       <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            pop_zero_q <= 1'b1;
        end else begin
            sp_q       <= sp_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            pop_zero_q <= pop_zero_d;
        end
    end

    // Storage array in read-first mode: a same-edge push+pop captures the old top.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_addr] <= bus.push_data;
        end
        if (do_pop) begin
            rd_data_q <= mem[top_addr];
        end
    end

    // The unreset RAM output register is masked to zero after reset or an empty pop.
    assign bus.pop_data = pop_zero_q ? '0 : rd_data_q;
    assign bus.sp       = sp_q;
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_stack_unit;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;

    logic clk;
    logic rst_n;

    stack_unit_if #(.WIDTH(WIDTH), .AW(AW)) bus_if ();

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of words plus result/flag variables.
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_pd;
    logic             m_ovf;
    logic             m_unf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_pd  = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            logic set_o, set_u;
            set_o = 1'b0;
            set_u = 1'b0;
            if (bus_if.push && bus_if.pop) begin
                if (m_q.size() == 0) begin
                    m_pd  = '0;
                    set_u = 1'b1;
                    m_q.push_back(bus_if.push_data);
                end else begin
                    m_pd = m_q[m_q.size()-1];
                    m_q[m_q.size()-1] = bus_if.push_data;
                end
            end else if (bus_if.push) begin
                if (m_q.size() == DEPTH) set_o = 1'b1;
                else m_q.push_back(bus_if.push_data);
            end else if (bus_if.pop) begin
                if (m_q.size() == 0) begin
                    m_pd  = '0;
                    set_u = 1'b1;
                end else begin
                    m_pd = m_q.pop_back();
                end
            end
            m_ovf = set_o || (m_ovf && !bus_if.err_clr);
            m_unf = set_u || (m_unf && !bus_if.err_clr);
        end
    end

    // Compare process: DUT against the model on every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("sp",       64'(bus_if.sp),       64'(m_q.size()));
            chk("empty",    64'(bus_if.empty),    64'(m_q.size() == 0));
            chk("full",     64'(bus_if.full),     64'(m_q.size() == DEPTH));
            chk("pop_data", 64'(bus_if.pop_data), 64'(m_pd));
            chk("ovf",      64'(bus_if.ovf),      64'(m_ovf));
            chk("unf",      64'(bus_if.unf),      64'(m_unf));
        end
    end

    // Apply one cycle of requests; returns 2 time units after the sampling edge.
    task automatic step(input logic ps, input logic pp, input logic [WIDTH-1:0] d,
                        input logic clr);
        bus_if.push      = ps;
        bus_if.pop       = pp;
        bus_if.push_data = d;
        bus_if.err_clr   = clr;
        @(posedge clk);
        #2;
        bus_if.push    = 1'b0;
        bus_if.pop     = 1'b0;
        bus_if.err_clr = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_words [3];
        exp_words[0] = 32'h3333_3333;
        exp_words[1] = 32'h2222_2222;
        exp_words[2] = 32'h1111_1111;

        bus_if.push      = 1'b0;
        bus_if.pop       = 1'b0;
        bus_if.err_clr   = 1'b0;
        bus_if.push_data = '0;
        rst_n = 1'b0;
        #12;
        chk("rst_sp",    64'(bus_if.sp),       64'd0);
        chk("rst_pd",    64'(bus_if.pop_data), 64'd0);
        chk("rst_empty", 64'(bus_if.empty),    64'd1);
        chk("rst_full",  64'(bus_if.full),     64'd0);
        chk("rst_ovf",   64'(bus_if.ovf),      64'd0);
        chk("rst_unf",   64'(bus_if.unf),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // LIFO ordering over three words.
        step(1, 0, 32'h1111_1111, 0);
        step(1, 0, 32'h2222_2222, 0);
        step(1, 0, 32'h3333_3333, 0);
        chk("lifo_sp3", 64'(bus_if.sp), 64'd3);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, '0, 0);
            chk("lifo_pd", 64'(bus_if.pop_data), 64'(exp_words[i]));
        end
        chk("lifo_sp0",   64'(bus_if.sp),    64'd0);
        chk("lifo_empty", 64'(bus_if.empty), 64'd1);

        // Push followed immediately by pop.
        step(1, 0, 32'hDEAD_BEEF, 0);
        step(0, 1, '0, 0);
        chk("b2b_pd", 64'(bus_if.pop_data), 64'hDEAD_BEEF);
        chk("b2b_sp", 64'(bus_if.sp),       64'd0);

        // Simultaneous push+pop replaces the top and returns the old top.
        step(1, 0, 32'hAAAA_0001, 0);
        step(1, 0, 32'hAAAA_0002, 0);
        step(1, 1, 32'h0000_5555, 0);
        chk("pp_pd", 64'(bus_if.pop_data), 64'hAAAA_0002);
        chk("pp_sp", 64'(bus_if.sp),       64'd2);
        step(0, 1, '0, 0);
        chk("pp_pop", 64'(bus_if.pop_data), 64'h0000_5555);
        step(0, 1, '0, 0);
        chk("pp_pop2", 64'(bus_if.pop_data), 64'hAAAA_0001);

        // Fill to capacity, overflow, then confirm the top survived.
        for (int i = 0; i < DEPTH; i++) step(1, 0, WIDTH'(i), 0);
        chk("fill_full", 64'(bus_if.full), 64'd1);
        chk("fill_sp",   64'(bus_if.sp),   64'd256);
        step(1, 0, 32'hFFFF_FFFF, 0);
        chk("ovf_flag", 64'(bus_if.ovf), 64'd1);
        chk("ovf_sp",   64'(bus_if.sp),  64'd256);
        step(0, 1, '0, 0);
        chk("ovf_top", 64'(bus_if.pop_data), 64'h0000_00FF);
        step(1, 1, 32'h0BAD_F00D, 0);
        chk("full_pp_pd", 64'(bus_if.pop_data), 64'h0000_00FE);
        step(1, 0, 32'h1234_5678, 0);
        step(1, 1, 32'h8765_4321, 0);
        chk("fullpp_noovf_sp", 64'(bus_if.sp), 64'd256);
        chk("fullpp_pd",       64'(bus_if.pop_data), 64'h1234_5678);
        step(0, 0, '0, 1);
        chk("ovf_clr", 64'(bus_if.ovf), 64'd0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, '0, 0);
        chk("drain_pd",    64'(bus_if.pop_data), 64'h0000_0000);
        chk("drain_empty", 64'(bus_if.empty),    64'd1);

        // Underflow, clear, and error-wins-over-clear.
        step(0, 1, '0, 0);
        chk("unf_flag", 64'(bus_if.unf),      64'd1);
        chk("unf_pd",   64'(bus_if.pop_data), 64'd0);
        chk("unf_sp",   64'(bus_if.sp),       64'd0);
        step(0, 0, '0, 1);
        chk("unf_clr", 64'(bus_if.unf), 64'd0);
        step(0, 1, '0, 1);
        chk("unf_win", 64'(bus_if.unf), 64'd1);
        step(1, 1, 32'h0000_00AB, 1);
        chk("empty_pp_sp",  64'(bus_if.sp),       64'd1);
        chk("empty_pp_pd",  64'(bus_if.pop_data), 64'd0);
        chk("empty_pp_unf", 64'(bus_if.unf),      64'd1);
        step(0, 1, '0, 1);
        chk("empty_pp_pop", 64'(bus_if.pop_data), 64'h0000_00AB);

        // Random traffic in phases alternating between push-heavy and pop-heavy.
        for (int ph = 0; ph < 10; ph++) begin
            int unsigned pbias;
            pbias = (ph % 2 == 0) ? 85 : 15;
            for (int c = 0; c < 400; c++) begin
                logic ps, pp, cl;
                ps = ($urandom_range(99) < pbias);
                pp = ($urandom_range(99) < (100 - pbias));
                cl = ($urandom_range(99) < 5);
                step(ps, pp, $urandom, cl);
            end
        end

        // Asynchronous reset in the middle of a cycle.
        step(1, 0, 32'h0000_0001, 0);
        step(1, 0, 32'h0000_0002, 0);
        step(1, 0, 32'h0000_0003, 0);
        step(0, 1, '0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_sp",    64'(bus_if.sp),       64'd0);
        chk("arst_pd",    64'(bus_if.pop_data), 64'd0);
        chk("arst_empty", 64'(bus_if.empty),    64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step(0, 1, '0, 0);
        chk("arst_unf", 64'(bus_if.unf),      64'd1);
        chk("arst_psp", 64'(bus_if.sp),       64'd0);
        chk("arst_ppd", 64'(bus_if.pop_data), 64'd0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
